// File: rtl/tag_access_icache_mw_pkg.sv
// Shared defaults, width helper and flush FSM encoding for the icache tag store.
// Optional refill-to-lookup bypass is enabled with ICACHE_TAG_BYPASS_EN.
package tag_access_icache_mw_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int TAG_WIDTH_DEF = 7;
  localparam int NUM_SET_DEF   = 32;
  localparam int NUM_WAY_DEF   = 4;
  localparam int SET_DEPTH_DEF = clog2(NUM_SET_DEF);
  localparam int WAY_DEPTH_DEF = clog2(NUM_WAY_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/tag_access_icache_mw_if.sv
// Fetch/refill/invalidate bus between the warp scheduler, miss path and tag store.
// master = requesting side, slave = tag store.
interface tag_access_icache_mw_if
  import tag_access_icache_mw_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int SET_DEPTH = SET_DEPTH_DEF,
  parameter int WAY_DEPTH = WAY_DEPTH_DEF
);
  logic                 r_req_valid_i;
  logic                 r_req_ready_o;
  logic [SET_DEPTH-1:0] r_req_setid_i;
  logic [TAG_WIDTH-1:0] tag_st1_i;
  logic                 hit_st1_o;
  logic [WAY_DEPTH-1:0] wayid_hit_st1_o;
  logic                 w_req_valid_i;
  logic [SET_DEPTH-1:0] w_req_setid_i;
  logic [TAG_WIDTH-1:0] w_req_tag_i;
  logic [WAY_DEPTH-1:0] w_req_wayid_o;
  logic                 inv_line_valid_i;
  logic                 inv_line_ready_o;
  logic [SET_DEPTH-1:0] inv_line_setid_i;
  logic [WAY_DEPTH-1:0] inv_line_wayid_i;
  logic                 inv_all_i;
  logic                 flush_busy_o;

  modport master (
    output r_req_valid_i, r_req_setid_i, tag_st1_i,
    output w_req_valid_i, w_req_setid_i, w_req_tag_i,
    output inv_line_valid_i, inv_line_setid_i, inv_line_wayid_i, inv_all_i,
    input  r_req_ready_o, hit_st1_o, wayid_hit_st1_o, w_req_wayid_o,
    input  inv_line_ready_o, flush_busy_o
  );

  modport slave (
    input  r_req_valid_i, r_req_setid_i, tag_st1_i,
    input  w_req_valid_i, w_req_setid_i, w_req_tag_i,
    input  inv_line_valid_i, inv_line_setid_i, inv_line_wayid_i, inv_all_i,
    output r_req_ready_o, hit_st1_o, wayid_hit_st1_o, w_req_wayid_o,
    output inv_line_ready_o, flush_busy_o
  );
endinterface

// File: rtl/tag_access_icache_mw_victim_sel.sv
// Refill victim picker: lowest invalid way, else the least recently used way
// decoded from a recency matrix (row i bit j set = way i used more recently than way j).
module icache_victim_sel
  import tag_access_icache_mw_pkg::*;
#(
  parameter int NUM_WAY   = NUM_WAY_DEF,
  parameter int WAY_DEPTH = clog2(NUM_WAY)
) (
  input  logic [NUM_WAY-1:0]         valid,
  input  logic [NUM_WAY*NUM_WAY-1:0] lru,
  output logic [WAY_DEPTH-1:0]       way
);
  logic [NUM_WAY-1:0] oldest;

  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_row
      logic [NUM_WAY-1:0] row;
      assign row        = lru[gi*NUM_WAY +: NUM_WAY];
      assign oldest[gi] = (row & ~(NUM_WAY'(1) << gi)) == '0;
    end
  endgenerate

  always_comb begin
    way = '0;
    if (&valid) begin
      for (int i = NUM_WAY - 1; i >= 0; i--) begin
        if (oldest[i]) way = WAY_DEPTH'(i);
      end
    end else begin
      for (int i = NUM_WAY - 1; i >= 0; i--) begin
        if (!valid[i]) way = WAY_DEPTH'(i);
      end
    end
  end
endmodule

// File: rtl/tag_access_icache_mw.sv
// L1 icache tag store: N-way lookup with one-cycle tag check, refill victim choice,
// line invalidate and a one-set-per-cycle flush sweep. Bypass option: ICACHE_TAG_BYPASS_EN.
module tag_access_icache_mw
  import tag_access_icache_mw_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int NUM_SET   = NUM_SET_DEF,
  parameter int NUM_WAY   = NUM_WAY_DEF,
  parameter int SET_DEPTH = clog2(NUM_SET),
  parameter int WAY_DEPTH = clog2(NUM_WAY)
) (
  input logic                   clk,
  input logic                   rst_n,
  tag_access_icache_mw_if.slave bus
);
  logic [NUM_WAY-1:0]         valid_reg [NUM_SET];
  logic [NUM_WAY*NUM_WAY-1:0] lru_reg [NUM_SET];
  flush_state_e               state_reg;
  logic [SET_DEPTH-1:0]       flush_cnt_reg;
  logic                       st1_valid_reg;
  logic                       st1_hazard_reg;
  logic [SET_DEPTH-1:0]       st1_setid_reg;
  logic [WAY_DEPTH-1:0]       byp_way_reg;
  logic [TAG_WIDTH-1:0]       byp_tag_reg;

  logic                 flushing, lookup_fire, refill_fire, inv_fire;
  logic [WAY_DEPTH-1:0] victim;
  logic [NUM_WAY-1:0]   victim_mask, st1_valid_word, match;
  logic                 hit;
  logic [WAY_DEPTH-1:0] hit_way;

  assign flushing    = (state_reg == FLUSH);
  assign lookup_fire = bus.r_req_valid_i && !flushing;
  assign refill_fire = bus.w_req_valid_i && !flushing;
  assign inv_fire    = bus.inv_line_valid_i && bus.inv_line_ready_o;

  assign bus.r_req_ready_o    = !flushing;
  assign bus.inv_line_ready_o = !bus.w_req_valid_i && !flushing;
  assign bus.flush_busy_o     = flushing;

  logic [NUM_WAY-1:0]         w_valid_word;
  logic [NUM_WAY*NUM_WAY-1:0] w_lru_word;
  assign w_valid_word = valid_reg[bus.w_req_setid_i];
  assign w_lru_word   = lru_reg[bus.w_req_setid_i];

  icache_victim_sel #(.NUM_WAY(NUM_WAY), .WAY_DEPTH(WAY_DEPTH)) u_victim_sel (
    .valid (w_valid_word),
    .lru   (w_lru_word),
    .way   (victim)
  );

  assign bus.w_req_wayid_o = victim;
  assign victim_mask       = NUM_WAY'(1) << victim;
  assign st1_valid_word    = valid_reg[st1_setid_reg];

  // One tag RAM per way: the victim mask gates the write, the read is registered on accept.
  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_way
      logic [TAG_WIDTH-1:0] tag_mem [NUM_SET];
      logic [TAG_WIDTH-1:0] tag_rd_reg;
      logic [TAG_WIDTH-1:0] cmp_tag;

      always_ff @(posedge clk) begin
        if (refill_fire && victim_mask[gi]) tag_mem[bus.w_req_setid_i] <= bus.w_req_tag_i;
        if (lookup_fire) tag_rd_reg <= tag_mem[bus.r_req_setid_i];
      end

`ifdef ICACHE_TAG_BYPASS_EN
      assign cmp_tag = (st1_hazard_reg && byp_way_reg == WAY_DEPTH'(gi)) ? byp_tag_reg : tag_rd_reg;
`else
      assign cmp_tag = tag_rd_reg;
`endif
      assign match[gi] = st1_valid_word[gi] && (cmp_tag == bus.tag_st1_i);
    end
  endgenerate

  always_comb begin
    hit_way = '0;
    for (int i = NUM_WAY - 1; i >= 0; i--) begin
      if (match[i]) hit_way = WAY_DEPTH'(i);
    end
`ifdef ICACHE_TAG_BYPASS_EN
    hit = st1_valid_reg && !flushing && (|match);
`else
    // Same-set refill during acceptance left stale tags in the read register.
    hit = st1_valid_reg && !flushing && !st1_hazard_reg && (|match);
`endif
    if (!hit) hit_way = '0;
  end

  assign bus.hit_st1_o       = hit;
  assign bus.wayid_hit_st1_o = hit_way;

  function automatic logic [NUM_WAY*NUM_WAY-1:0] lru_touch(
    input logic [NUM_WAY*NUM_WAY-1:0] m,
    input logic [WAY_DEPTH-1:0]       w
  );
    logic [NUM_WAY*NUM_WAY-1:0] r;
    r = m;
    for (int i = 0; i < NUM_WAY; i++) begin
      r[int'(w)*NUM_WAY + i] = (i != int'(w));
      r[i*NUM_WAY + int'(w)] = 1'b0;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      flush_cnt_reg  <= '0;
      st1_valid_reg  <= 1'b0;
      st1_hazard_reg <= 1'b0;
      st1_setid_reg  <= '0;
      byp_way_reg    <= '0;
      byp_tag_reg    <= '0;
      for (int s = 0; s < NUM_SET; s++) begin
        valid_reg[s] <= '0;
        lru_reg[s]   <= '0;
      end
    end else begin
      st1_valid_reg  <= lookup_fire;
      st1_hazard_reg <= lookup_fire && refill_fire && (bus.r_req_setid_i == bus.w_req_setid_i);
      if (lookup_fire) st1_setid_reg <= bus.r_req_setid_i;
      if (refill_fire) begin
        byp_way_reg <= victim;
        byp_tag_reg <= bus.w_req_tag_i;
      end

      case (state_reg)
        IDLE: begin
          if (bus.inv_all_i) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= '0;
          end
        end
        FLUSH: begin
          flush_cnt_reg <= flush_cnt_reg + 1'b1;
          if (flush_cnt_reg == SET_DEPTH'(NUM_SET - 1)) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (flushing) valid_reg[flush_cnt_reg] <= '0;
      else if (refill_fire) valid_reg[bus.w_req_setid_i] <= w_valid_word | victim_mask;
      else if (inv_fire) valid_reg[bus.inv_line_setid_i][bus.inv_line_wayid_i] <= 1'b0;

      if (refill_fire) lru_reg[bus.w_req_setid_i] <= lru_touch(w_lru_word, victim);
      // A refill to the hit set owns that set's LRU update this cycle.
      if (hit && !(refill_fire && bus.w_req_setid_i == st1_setid_reg))
        lru_reg[st1_setid_reg] <= lru_touch(lru_reg[st1_setid_reg], hit_way);
    end
  end
endmodule

// File: doc/tag_access_icache_mw.md
# tag_access_icache_mw

Parametrised instruction-cache tag store and hit logic for the SM L1 icache. It supports N-way lookup with a one-cycle tag-check stage. Refills write a single tag into a victim way, chosen as the first invalid way, otherwise the LRU way. It also provides single-line invalidation, a multi-cycle full-flush sweep with back-pressure, and optional refill-to-lookup bypass. It sits between the warp-scheduler fetch request and the icache data array and miss path.

## Interface
- TAG_WIDTH, 7, tag bits per line
- NUM_SET, 32, sets (power of 2)
- NUM_WAY, 4, ways per set (power of 2, ≥2)
- SET_DEPTH, 5, log2(NUM_SET)
- WAY_DEPTH, 2, log2(NUM_WAY)

Ports:
- clk  in  1  clock; the block uses this one clock only
- rst_n  in  1  asynchronous, active-low reset
- r_req_valid_i  in  1  lookup request (st0)
- r_req_ready_o  out  1  lookup accepted when valid&ready
- r_req_setid_i  in  SET_DEPTH  lookup set
- tag_st1_i  in  TAG_WIDTH  core tag, presented one cycle after acceptance
- hit_st1_o  out  1  st1 hit
- wayid_hit_st1_o  out  WAY_DEPTH  st1 hit way (0 on miss)
- w_req_valid_i  in  1  refill tag write
- w_req_setid_i  in  SET_DEPTH  refill set
- w_req_tag_i  in  TAG_WIDTH  refill tag
- w_req_wayid_o  out  WAY_DEPTH  victim way for w_req_setid_i (combinational; data array uses same way)
- inv_line_valid_i  in  1  single-line invalidate
- inv_line_ready_o  out  1  invalidate accepted when valid&ready
- inv_line_setid_i  in  SET_DEPTH  invalidate set
- inv_line_wayid_i  in  WAY_DEPTH  invalidate way
- inv_all_i  in  1  full-flush request pulse
- flush_busy_o  out  1  flush sweep in progress

## Operation
- Storage:
  - Tag SRAM: NUM_SET × NUM_WAY × TAG_WIDTH, 1R1W, way-masked write.
  - Valid store: NUM_SET words of NUM_WAY bits, one write port per cycle.
  - LRU: one lru_matrix per set.
- Lookup:
  - An accepted request reads the set's tags.
  - Next cycle (st1), each way compares against tag_st1_i, qualified by that way's current valid bit.
  - hit_st1_o = any match. wayid_hit_st1_o = lowest matching index.
- Victim selection: lowest-index invalid way in w_req_setid_i; if the set is full, the lru_matrix output.
- Refill: writes w_req_tag_i into the victim way, sets its valid bit, and updates that set's LRU with the victim way.
- LRU update on hit: set = registered st1 setid, way = wayid_hit_st1_o.
  - Same-set hit and refill in one cycle: refill update wins and the hit update is dropped.
  - Different sets: both update.
- Line invalidate: clears valid[set][way]. LRU is untouched.
  - inv_line_ready_o = !w_req_valid_i && !flush_busy_o.
- Valid-store write-port priority: flush clear > refill > line invalidate.
- Flush FSM, states IDLE and FLUSH:
  - IDLE→FLUSH on inv_all_i. A set counter starts at 0, clears one set's valid word per cycle, and increments.
  - FLUSH→IDLE after clearing set NUM_SET-1, so FLUSH lasts exactly NUM_SET cycles. The counter wraps to 0.
  - inv_all_i during FLUSH is ignored.
  - LRU state is not reset by flush.
- During FLUSH:
  - r_req_ready_o=0.
  - w_req_valid_i is dropped: no tag write, no valid set, no LRU update.
  - hit_st1_o is forced 0.
- Reset mid-flush: state returns to IDLE and all valid bits clear.

## Timing
- Reset values: hit_st1_o 0, wayid_hit_st1_o 0, flush_busy_o 0, r_req_ready_o 1, inv_line_ready_o 1 (while w_req_valid_i=0), w_req_wayid_o 0. All valid bits 0; LRU at reset state.
- Lookup latency: accept in cycle N → hit/way valid combinationally in N+1. There is no stall, so a new lookup may be accepted every cycle.
- Refill and invalidate take effect at the end of their cycle. A lookup's st1 in N+1 sees valid-bit changes made in cycle N.
- Hazard: a refill to the same set in the lookup's acceptance cycle N leaves stale SRAM data at st1. Handling depends on the macro (see Configuration).
- Refill in the st1 cycle itself is not visible to that st1 result.
- flush_busy_o rises in the cycle after inv_all_i and falls after NUM_SET cycles.

## Configuration
- ICACHE_TAG_BYPASS_EN defined: a refill registered in cycle N with matching set substitutes w_req_tag_i for the victim way's tag at st1 in N+1. The result is exact.
- ICACHE_TAG_BYPASS_EN undefined: in the same case, hit_st1_o is forced 0 and wayid_hit_st1_o to 0 (conservative miss), and the LRU is not updated by that st1.

## Structure
- A shared package/header holds the parameter defaults, the clog2 helper, and the flush FSM state encoding (IDLE=0, FLUSH=1).
- Reuse existing sub-modules: lru_matrix (per set), sram_template (tags), bin2one (victim way to write mask).
- One new sub-module, icache_victim_sel: invalid-first/LRU victim picker.

## Test plan
- Reset, refill set 3 tag 0x2A → w_req_wayid_o=0. Lookup set 3 with tag 0x2A → hit_st1_o=1, way 0, one cycle after accept.
- Fill set 5 with four tags A,B,C,D into ways 0..3, then hit way 0 → the next refill to set 5 picks way 1 (LRU). Invalidate way 2 → the next refill picks way 2.
- Refill set 7 way 1 tag 0x11 in the same cycle a set-7 lookup is accepted, st1 tag 0x11 → hit=1/way 1 with bypass; hit=0 without bypass.
- Pulse inv_all_i with NUM_SET=32 → flush_busy_o high for exactly 32 cycles and r_req_ready_o low throughout. A refill during the sweep is dropped. A subsequent lookup of a prior tag misses.
- Line invalidate asserted together with a refill → inv_line_ready_o=0. The invalidate is accepted on the next cycle, and the targeted way then misses.
- Assert rst_n low at flush cycle 10 → flush_busy_o=0 immediately and all lookups miss after release.
